// File: rtl/fir_filter_prog.sv
// Programmable direct-form FIR filter: TAPS coefficients written over a small
// register port, three registered stages (products, sum, saturated output).
module fir_filter_prog #(
    parameter int TAPS   = 15,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [5:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data
);

    // Valid semantics: in_valid marks a sample taken at that rising edge (no
    // backpressure); out_valid is a one-cycle pulse and out_data holds otherwise.

    localparam int   PROD_W = DATA_W + COEF_W;
    localparam int   ACC_W  = PROD_W + $clog2(TAPS);
    localparam logic SGN    = (SIGNED != 0);

    logic [COEF_W-1:0] coef  [TAPS];
    logic [DATA_W-1:0] dline [TAPS];
    logic [PROD_W-1:0] prod  [TAPS];
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [OUT_W-1:0]  sat_data;
    logic [2:0]        vpipe;  // [0] new sample in dline, [1] products, [2] sum

    function automatic logic [PROD_W-1:0] ext_d(input logic [DATA_W-1:0] d);
        return {{COEF_W{SGN & d[DATA_W-1]}}, d};
    endfunction

    function automatic logic [PROD_W-1:0] ext_c(input logic [COEF_W-1:0] c);
        return {{DATA_W{SGN & c[COEF_W-1]}}, c};
    endfunction

    function automatic logic [ACC_W-1:0] ext_p(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){SGN & p[PROD_W-1]}}, p};
    endfunction

    // Writes to tap indices at or beyond TAPS match no register and are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == 6'(k)) coef[k] <= coef_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
            vpipe <= '0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
            vpipe <= '0;
        end else begin
            if (in_valid) begin
                dline[0] <= in_data;
                for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
            end
            vpipe <= {vpipe[1:0], in_valid};
        end
    end

    // Modular multiply of extended operands yields the exact product in PROD_W bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
            acc <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod[k] <= ext_d(dline[k]) * ext_c(coef[k]);
            acc <= acc_sum;
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) acc_sum = acc_sum + ext_p(prod[k]);
    end

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            always_comb begin
                if (SGN) sat_data = OUT_W'($signed(acc));
                else     sat_data = OUT_W'(acc);
            end
        end else begin : g_sat
            logic [ACC_W-OUT_W:0] top_bits;
            assign top_bits = acc[ACC_W-1:OUT_W-1];
            always_comb begin
                sat_data = acc[OUT_W-1:0];
                if (SGN) begin
                    if (!(&top_bits) && (|top_bits))
                        sat_data = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                : {1'b0, {(OUT_W-1){1'b1}}};
                end else if (|top_bits[ACC_W-OUT_W:1]) begin
                    sat_data = '1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vpipe[2] & ~clear;
            if (vpipe[2] && !clear) out_data <= sat_data;
        end
    end

endmodule

// File: tb/tb_fir_filter_prog.sv
// Bench for fir_filter_prog: default instance plus a small signed saturating
// instance, each with an expected-value queue checked by its own monitor.
module tb_fir_filter_prog;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          edge_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    logic        clear = 0, in_valid = 0, coef_we = 0;
    logic [7:0]  in_data = '0, coef_data = '0;
    logic [5:0]  coef_addr = '0;
    logic        out_valid;
    logic [19:0] out_data;

    logic        b_clear = 0, b_in_valid = 0, b_coef_we = 0;
    logic [7:0]  b_in_data = '0, b_coef_data = '0;
    logic [5:0]  b_coef_addr = '0;
    logic        b_out_valid;
    logic [11:0] b_out_data;

    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [11:0] b_exp_q[$];
    int          b_cyc_q[$];
    logic [19:0] last_exp = '0;

    logic [19:0] imp_tab [15] = '{7, 8, 9, 12, 4, 7, 8, 9, 12, 4, 7, 8, 9, 12, 4};
    logic [19:0] step_tab[15] = '{1785, 3825, 6120, 9180, 10200, 11985, 14025, 16320,
                                  19380, 20400, 22185, 24225, 26520, 29580, 30600};
    logic [19:0] ctl_tab [4]  = '{14, 30, 48, 72};

    fir_filter_prog dut (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data)
    );

    fir_filter_prog #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_W(12), .SIGNED(1)) dut_s (
        .clock(clock), .reset(reset), .clear(b_clear), .in_valid(b_in_valid),
        .in_data(b_in_data), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
        .coef_data(b_coef_data), .out_valid(b_out_valid), .out_data(b_out_data)
    );

    // clock / edge counter
    initial forever #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks (start and end at a falling edge)
    task automatic cyc(input logic v, input logic [7:0] d, input logic clr,
                       input logic [19:0] e, input logic want);
        in_valid = v; in_data = d; clear = clr;
        if (want) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(edge_cnt + 4);
        end
        @(posedge clock); @(negedge clock);
        in_valid = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'($urandom_range(0, 255)), 0, '0, 0);
    endtask

    task automatic write_coef(input logic [5:0] a, input logic [7:0] d);
        coef_we = 1; coef_addr = a; coef_data = d;
        @(posedge clock); @(negedge clock);
        coef_we = 0;
    endtask

    task automatic b_cyc(input logic v, input logic [7:0] d, input logic clr,
                         input logic [11:0] e, input logic want);
        b_in_valid = v; b_in_data = d; b_clear = clr;
        if (want) begin
            b_exp_q.push_back(e);
            b_cyc_q.push_back(edge_cnt + 4);
        end
        @(posedge clock); @(negedge clock);
        b_in_valid = 0; b_clear = 0;
    endtask

    task automatic b_write_coef(input logic [5:0] a, input logic [7:0] d);
        b_coef_we = 1; b_coef_addr = a; b_coef_data = d;
        @(posedge clock); @(negedge clock);
        b_coef_we = 0;
    endtask

    // scoreboard monitors
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got out_data %0h expected no output", out_data);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(last_exp));
                    check("latency", 32'(edge_cnt), 32'(exp_cyc_q.pop_front()));
                end
            end else begin
                check("hold", 32'(out_data), 32'(last_exp));
            end
        end
    end

    always @(negedge clock) begin
        if (reset && b_out_valid) begin
            if (b_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_out_valid: got out_data %0h expected no output", b_out_data);
            end else begin
                check("b_out_data", 32'(b_out_data), 32'(b_exp_q.pop_front()));
                check("b_latency", 32'(edge_cnt), 32'(b_cyc_q.pop_front()));
            end
        end
    end

    initial begin
        #1 reset = 0;
        repeat (2) @(negedge clock);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        reset = 1;
        @(negedge clock);

        // coefficients, plus an out-of-range write that must be ignored
        for (int i = 0; i < 15; i++) write_coef(6'(i), imp_tab[i][7:0]);
        write_coef(6'd20, 8'd99);

        // impulse
        for (int k = 0; k < 15; k++) cyc(1, (k == 0) ? 8'd1 : 8'd0, 0, imp_tab[k], 1);
        idle(4); cyc(0, 0, 1, '0, 0);

        // step
        for (int k = 0; k < 18; k++) cyc(1, 8'd255, 0, (k < 15) ? step_tab[k] : 20'd30600, 1);
        idle(4); cyc(0, 0, 1, '0, 0);

        // impulse with bubbles carrying junk data
        for (int k = 0; k < 15; k++) begin
            cyc(1, (k == 0) ? 8'd1 : 8'd0, 0, imp_tab[k], 1);
            cyc(0, 8'($urandom_range(1, 255)), 0, '0, 0);
        end
        idle(4); cyc(0, 0, 1, '0, 0);

        // short stream, then clear colliding with a sample, then impulse
        for (int k = 0; k < 4; k++) cyc(1, 8'd2, 0, ctl_tab[k], 1);
        idle(3);
        cyc(1, 8'd77, 1, '0, 0);
        for (int k = 0; k < 15; k++) cyc(1, (k == 0) ? 8'd1 : 8'd0, 0, imp_tab[k], 1);
        idle(4); cyc(0, 0, 1, '0, 0);

        // reset mid-stream while the first result is on the outputs
        cyc(1, 8'd5, 0, 20'd35, 1);
        for (int k = 0; k < 3; k++) cyc(1, 8'd5, 0, '0, 0);
        #2 reset = 0;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_out_data", 32'(out_data), 32'd0);
        last_exp = '0;
        @(negedge clock); @(negedge clock);
        reset = 1;
        @(negedge clock);
        for (int k = 0; k < 15; k++) cyc(1, (k == 0) ? 8'd1 : 8'd0, 0, 20'd0, 1);
        idle(6);

        // signed saturating instance
        for (int i = 0; i < 4; i++) b_write_coef(6'(i), 8'd127);
        for (int k = 0; k < 6; k++) b_cyc(1, 8'd127, 0, 12'h7FF, 1);
        idle(4); b_cyc(0, 0, 1, '0, 0);
        for (int k = 0; k < 6; k++) b_cyc(1, 8'h80, 0, 12'h800, 1);
        idle(4); b_cyc(0, 0, 1, '0, 0);
        for (int k = 0; k < 4; k++) b_cyc(1, (k == 0) ? 8'd1 : 8'd0, 0, 12'd127, 1);
        for (int k = 0; k < 4; k++) b_cyc(1, (k == 0) ? 8'hFF : 8'd0, 0, 12'hF81, 1);
        idle(8);

        check("drain_a", 32'(exp_q.size()), 32'd0);
        check("drain_b", 32'(b_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
